oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/ppu_pkg.sv | 23 ++
 rtl/oam_dma_if.sv | 34 +++
 rtl/oam_dma_ctrl.sv | 92 +++++++++
 tb/tb_oam_dma_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA state encoding, default trigger address
// and transfer length, plus the trigger decode helper.
package ppu_pkg;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'h4014;
    localparam int          XFER_LEN_DEFAULT     = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } dma_state_t;

    function automatic logic is_dma_trigger(input logic        we,
                                            input logic [15:0] addr,
                                            input logic [15:0] reg_addr);
        return we && (addr == reg_addr);
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-bus / memory / OAM signal bundle around the OAM DMA controller.
// master = CPU bus + memory side, slave = the DMA controller.
interface oam_dma_if;

    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        WE;
    logic [7:0]  oam_addr_start;
    logic [7:0]  mem_data_in;
    logic        cpu_halt;
    logic        dma_rd;
    logic [15:0] dma_addr_out;
    logic        oam_we;
    logic [7:0]  oam_addr_out;
    logic [7:0]  oam_data_out;
    logic        busy;
    logic        done;

    // Handshake: a CPU write is a single-cycle WE pulse qualified by
    // cpu_addr_in; memory answers a dma_rd strobe with mem_data_in on the
    // following cycle, and oam_we is a single-cycle write strobe.
    modport master (
        output cpu_addr_in, cpu_data_in, WE, oam_addr_start, mem_data_in,
        input  cpu_halt, dma_rd, dma_addr_out, oam_we, oam_addr_out,
               oam_data_out, busy, done
    );

    modport slave (
        input  cpu_addr_in, cpu_data_in, WE, oam_addr_start, mem_data_in,
        output cpu_halt, dma_rd, dma_addr_out, oam_we, oam_addr_out,
               oam_data_out, busy, done
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG_ADDR halts the CPU and copies
// XFER_LEN bytes from page {cpu_data_in, 00} into OAM starting at OAMADDR.
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
    parameter int          XFER_LEN     = XFER_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        WE,
    input  logic [7:0]  oam_addr_start,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_halt,
    output logic        dma_rd,
    output logic [15:0] dma_addr_out,
    output logic        oam_we,
    output logic [7:0]  oam_addr_out,
    output logic [7:0]  oam_data_out,
    output logic        busy,
    output logic        done,
    output dma_state_t  dbg_state
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t r_state;
    logic [7:0] r_idx;
    logic [7:0] r_page;
    logic [7:0] r_oam_base;
    logic       r_parity;

    logic w_trigger;
    logic w_in_read;
    logic w_in_write;

    assign w_trigger = is_dma_trigger(WE, cpu_addr_in, DMA_REG_ADDR);

    // r_parity models the CPU get/put cycle phase; an odd phase at HALT
    // costs one extra ALIGN cycle before the first read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= 8'h00;
            r_page     <= 8'h00;
            r_oam_base <= 8'h00;
            r_parity   <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_page     <= cpu_data_in;
                        r_oam_base <= oam_addr_start;
                        r_idx      <= 8'h00;
                        r_state    <= ST_HALT;
                    end
                end
                ST_HALT:  r_state <= r_parity ? ST_ALIGN : ST_READ;
                ST_ALIGN: r_state <= ST_READ;
                ST_READ:  r_state <= ST_WRITE;
                ST_WRITE: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= ST_READ;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_in_read  = (r_state == ST_READ);
    assign w_in_write = (r_state == ST_WRITE);

    // Outputs decode registered state only, so reset clears them immediately.
    assign cpu_halt     = (r_state != ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign dma_rd       = w_in_read;
    assign dma_addr_out = w_in_read ? {r_page, r_idx} : 16'h0000;
    assign oam_we       = w_in_write;
    assign oam_addr_out = w_in_write ? (r_oam_base + r_idx) : 8'h00;
    assign oam_data_out = w_in_write ? mem_data_in : 8'h00;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: scoreboarded reads/OAM writes,
// halt-length and alignment checks, ignored triggers and mid-transfer reset.
module tb_oam_dma_ctrl;
    import ppu_pkg::*;

    logic       clk;
    logic       rst;
    dma_state_t dbg_state;
    oam_dma_if  bus ();

    oam_dma_ctrl dut (
        .clk            (clk),
        .reset          (rst),
        .cpu_addr_in    (bus.cpu_addr_in),
        .cpu_data_in    (bus.cpu_data_in),
        .WE             (bus.WE),
        .oam_addr_start (bus.oam_addr_start),
        .mem_data_in    (bus.mem_data_in),
        .cpu_halt       (bus.cpu_halt),
        .dma_rd         (bus.dma_rd),
        .dma_addr_out   (bus.dma_addr_out),
        .oam_we         (bus.oam_we),
        .oam_addr_out   (bus.oam_addr_out),
        .oam_data_out   (bus.oam_data_out),
        .busy           (bus.busy),
        .done           (bus.done),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt = 0;
        else     edge_cnt = edge_cnt + 1;
    end

    // scoreboard state
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_rd_q[$];
    logic [15:0] exp_wr_q[$];
    int          exp_len_q[$];
    int          exp_off_q[$];
    int halt_len  = 0;
    int busy_len  = 0;
    int done_cnt  = 0;
    int first_off = -1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_halt"},  bus.cpu_halt,     0);
        check({tag, "_rd"},    bus.dma_rd,       0);
        check({tag, "_raddr"}, bus.dma_addr_out, 0);
        check({tag, "_we"},    bus.oam_we,       0);
        check({tag, "_waddr"}, bus.oam_addr_out, 0);
        check({tag, "_wdata"}, bus.oam_data_out, 0);
        check({tag, "_busy"},  bus.busy,         0);
        check({tag, "_done"},  bus.done,         0);
    endtask

    // memory model: answers a dma_rd on the following cycle, junk otherwise
    initial begin
        logic        pend;
        logic [15:0] a;
        bus.mem_data_in = 8'h00;
        forever begin
            @(negedge clk);
            pend = bus.dma_rd;
            a    = bus.dma_addr_out;
            @(posedge clk);
            #1 bus.mem_data_in = pend ? mem_byte(a) : 8'($urandom_range(0, 255));
        end
    end

    // output monitor / scoreboard comparison
    initial begin
        int el, eo;
        forever begin
            @(negedge clk);
            if (rst) begin
                check_all_zero("in_reset");
                if (halt_len > 0 || busy_len > 0) check("abort_no_done", done_cnt, 0);
                halt_len = 0; busy_len = 0; done_cnt = 0; first_off = -1;
            end else begin
                if (bus.dma_rd) begin
                    if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
                    else check("rd_addr", bus.dma_addr_out, exp_rd_q.pop_front());
                end else begin
                    check("rd_addr_idle", bus.dma_addr_out, 0);
                end
                if (bus.oam_we) begin
                    if (exp_wr_q.size() == 0) check("wr_extra", 1, 0);
                    else check("oam_wr", {bus.oam_addr_out, bus.oam_data_out}, exp_wr_q.pop_front());
                end else begin
                    check("oam_idle", {bus.oam_addr_out, bus.oam_data_out}, 0);
                end
                if (bus.cpu_halt) begin
                    if (bus.dma_rd && first_off < 0) first_off = halt_len;
                    halt_len++;
                end
                if (bus.busy) busy_len++;
                if (bus.done) done_cnt++;
                if (!bus.cpu_halt && !bus.busy && (halt_len > 0 || busy_len > 0)) begin
                    if (exp_len_q.size() == 0) begin
                        check("halt_extra", 1, 0);
                    end else begin
                        el = exp_len_q.pop_front();
                        eo = exp_off_q.pop_front();
                        check("halt_len",  halt_len,  el);
                        check("busy_len",  busy_len,  el);
                        check("done_cnt",  done_cnt,  1);
                        check("first_rd",  first_off, eo);
                    end
                    halt_len = 0; busy_len = 0; done_cnt = 0; first_off = -1;
                end
            end
        end
    end

    // driver tasks
    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        bus.WE = 1'b1; bus.cpu_addr_in = addr; bus.cpu_data_in = data;
        @(negedge clk);
        bus.WE = 1'b0;
        bus.cpu_addr_in = 16'($urandom_range(0, 16'h3FFF));
        bus.cpu_data_in = 8'($urandom_range(0, 255));
    endtask

    // the trigger posedge index fixes the parity seen in HALT
    task automatic trigger(input logic [7:0] page, input logic [7:0] base, input bit par);
        @(negedge clk);
        if (((edge_cnt + 1) % 2) != int'(par)) @(negedge clk);
        bus.oam_addr_start = base;
        for (int i = 0; i < 256; i++) begin
            exp_rd_q.push_back({page, 8'(i)});
            exp_wr_q.push_back({8'(base + 8'(i)), mem_byte({page, 8'(i)})});
        end
        exp_len_q.push_back(514 + int'(par));
        exp_off_q.push_back(1 + int'(par));
        cpu_write(16'h4014, page);
        bus.oam_addr_start = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.cpu_halt) begin ok = 1'b1; break; end
        end
        if (!ok) check("wait_idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rd_idx(input logic [7:0] idx);
        bit ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (bus.dma_rd && bus.dma_addr_out[7:0] == idx) begin ok = 1'b1; break; end
        end
        if (!ok) check("wait_rd_timeout", 1, 0);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1'b1; break; end
        end
        if (!ok) check("wait_done_timeout", 1, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_halt"},  bus.cpu_halt, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_rd"},    bus.dma_rd, 0);
        check({tag, "_we"},    bus.oam_we, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // main sequence
    initial begin
        rst = 1'b1;
        bus.WE = 1'b0; bus.cpu_addr_in = 16'h0000; bus.cpu_data_in = 8'h00;
        bus.oam_addr_start = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("after_reset");

        // basic transfers, both parities, page 02 / OAM 00
        trigger(8'h02, 8'h00, 1'b0);
        wait_idle();
        trigger(8'h02, 8'h00, 1'b1);
        wait_idle();

        // OAM address wrap from F0
        trigger(8'h07, 8'hF0, 1'($urandom_range(0, 1)));
        wait_idle();

        // retrigger mid-transfer is ignored
        trigger(8'h02, 8'($urandom_range(0, 255)), 1'b0);
        wait_rd_idx(8'd10);
        bus.oam_addr_start = 8'h33;
        cpu_write(16'h4014, 8'h05);
        wait_idle();

        // trigger on the DONE->IDLE edge is ignored
        trigger(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
        wait_done();
        cpu_write(16'h4014, 8'h09);
        repeat (3) @(negedge clk);
        check_idle("done_edge");
        wait_idle();

        // asynchronous reset mid-transfer, then a clean transfer
        trigger(8'h02, 8'h00, 1'b0);
        wait_rd_idx(8'd100);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        check("async_rst_state", dbg_state, ST_IDLE);
        exp_rd_q.delete(); exp_wr_q.delete(); exp_len_q.delete(); exp_off_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("post_rst");
        trigger(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        wait_idle();

        // writes to other addresses do nothing
        @(negedge clk);
        cpu_write(16'h2004, 8'h03);
        cpu_write(16'h4015, 8'h03);
        repeat (4) @(negedge clk);
        check_idle("other_addr");
        check_all_zero("other_addr");

        check("rd_q_left",  exp_rd_q.size(),  0);
        check("wr_q_left",  exp_wr_q.size(),  0);
        check("len_q_left", exp_len_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
